// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Single-port controller for an external asynchronous 256K x 16 SRAM with
// active-low CSX/OEX/WEX strobes and a shared bidirectional 16-bit data bus.
// A level write request (WE) is turned into a setup cycle followed by a WEX
// low pulse. At all other times the SRAM is held in continuous read mode and
// the bus contents are registered into DATA_READ.
//
// Ports:
//   CLK         in   1   system clock, rising edge
//   RST         in   1   synchronous active-high reset
//   WE          in   1   write request level (1 = write, 0 = read)
//   ADDRESS     in   18  word address; wired to the SRAM pins at the top level
//   DATA        inout 16 SRAM data pins
//   DATA_WRITE  in   16  write data
//   DATA_READ   out  16  registered read data
//   CSX         out  1   SRAM chip select, active low, registered
//   OEX         out  1   SRAM output enable, active low, registered
//   WEX         out  1   SRAM write enable, active low, registered
//
// Build option: define SRAM_SB_IO_EN to implement the DATA pins with iCE40
// SB_IO primitives; otherwise a generic tristate is inferred. State timing is
// the same in both builds.
// -----------------------------------------------------------------------------
module sram_controller (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WE,
  input  logic [17:0] ADDRESS,
  inout  wire  [15:0] DATA,
  input  logic [15:0] DATA_WRITE,
  output logic [15:0] DATA_READ,
  output logic        CSX,
  output logic        OEX,
  output logic        WEX
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TURN     = 3'd1,
    READ     = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        csx_q, csx_d;
  logic        oex_q, oex_d;
  logic        wex_q, wex_d;
  logic [15:0] data_read_q;
  logic        drive_en;
  logic [15:0] data_in;

  // ADDRESS goes straight to the SRAM pins outside this block; it is only
  // part of the port list so the requester interface is complete.
  logic unused_address;
  assign unused_address = ^ADDRESS;

  // ---------------------------------------------------------------------------
  // State register (strobes are registered alongside the state)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      csx_q   <= 1'b1;
      oex_q   <= 1'b1;
      wex_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      csx_q   <= csx_d;
      oex_q   <= oex_d;
      wex_q   <= wex_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = WE ? WR_SETUP : TURN;
      TURN:     state_d = WE ? WR_SETUP : READ;
      READ:     state_d = WE ? WR_SETUP : READ;
      WR_SETUP: state_d = WE ? WR_PULSE : TURN;
      WR_PULSE: state_d = WE ? WR_PULSE : TURN;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode, computed from the upcoming state so that the registered
  // strobes change on the same edge the state does.
  // ---------------------------------------------------------------------------
  always_comb begin
    csx_d = 1'b1;
    oex_d = 1'b1;
    wex_d = 1'b1;
    case (state_d)
      IDLE: begin
      end
      TURN: begin
        csx_d = 1'b0;
      end
      READ: begin
        csx_d = 1'b0;
        oex_d = 1'b0;
      end
      WR_SETUP: begin
        csx_d = 1'b0;
      end
      WR_PULSE: begin
        csx_d = 1'b0;
        wex_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus drive enable. Taken directly from WE so the bus is released in the
  // same cycle the request drops; OEX is high in both write states, so the
  // SRAM is never enabled onto the bus while we drive it.
  // ---------------------------------------------------------------------------
  assign drive_en = WE && !RST && ((state_q == WR_SETUP) || (state_q == WR_PULSE));

`ifdef SRAM_SB_IO_EN
  // Registered-free bidirectional pads: output driven combinationally with
  // tristate control, input taken unregistered from D_IN_0.
  for (genvar gi = 0; gi < 16; gi++) begin : g_data_io
    SB_IO #(
      .PIN_TYPE(6'b101001),
      .PULLUP  (1'b0)
    ) u_data_io (
      .PACKAGE_PIN  (DATA[gi]),
      .OUTPUT_ENABLE(drive_en),
      .D_OUT_0      (DATA_WRITE[gi]),
      .D_IN_0       (data_in[gi])
    );
  end
`else
  assign DATA    = drive_en ? DATA_WRITE : 16'hzzzz;
  assign data_in = DATA;
`endif

  // ---------------------------------------------------------------------------
  // Read data capture: sample the bus on every edge spent in READ, hold
  // otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_read_q <= 16'h0000;
    end else if (state_q == READ) begin
      data_read_q <= data_in;
    end
  end

  assign DATA_READ = data_read_q;
  assign CSX       = csx_q;
  assign OEX       = oex_q;
  assign WEX       = wex_q;

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Bench for sram_controller. An asynchronous SRAM model sits on the shared
// bus. The reference model predicts the strobes from the run length of WE
// samples since the last reset or last change of WE, tracks the expected
// memory contents in a plain array, and predicts DATA_READ from that array.
// Directed sequences with literal expectations run first, then randomized
// read/write/reset traffic.
// -----------------------------------------------------------------------------
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [17:0] addr;
  logic [15:0] dw;
  wire  [15:0] data_read;
  wire         csx, oex, wex;
  tri   [15:0] data_bus;

  always #5 clk = ~clk;

  sram_controller dut (
    .CLK       (clk),
    .RST       (rst),
    .WE        (we),
    .ADDRESS   (addr),
    .DATA      (data_bus),
    .DATA_WRITE(dw),
    .DATA_READ (data_read),
    .CSX       (csx),
    .OEX       (oex),
    .WEX       (wex)
  );

  // ---------------------------------------------------------------------------
  // External SRAM model: drives the bus when selected and output-enabled,
  // latches the bus while selected with WEX low and write data presented.
  // ---------------------------------------------------------------------------
  logic [15:0] sram_mem [0:262143];
  logic [15:0] ref_mem  [0:262143];
  wire         sram_oe = !csx && !oex && wex;

  assign data_bus = sram_oe ? sram_mem[addr] : 16'hzzzz;

  always @(negedge clk) begin
    if (!csx && !wex && we && !rst)
      sram_mem[addr] <= data_bus;
  end

  function automatic logic [15:0] init_word(input logic [17:0] a);
    init_word = 16'hC3A5 ^ a[15:0] ^ {14'd0, a[17:16]};
  endfunction

  // ---------------------------------------------------------------------------
  // Counters and check helpers
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
    tests++;
    if (act === bad) begin
      fails++;
      $display("FAIL %s: got %h, must not be %h (bus should be released)", name, act, bad);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //   After a reset edge: all strobes high, DATA_READ = 0.
  //   Otherwise, with run1/run0 = number of consecutive WE=1/WE=0 samples:
  //     WE=1: run1==1 -> setup (CS low), run1>=2 -> WE strobe low
  //     WE=0: run0==1 -> turnaround (CS low), run0>=2 -> OE low (reading)
  //   DATA_READ takes the addressed word at any edge that ends a reading cycle.
  // ---------------------------------------------------------------------------
  bit          model_valid = 1'b0;
  int          run1 = 0;
  int          run0 = 0;
  logic        exp_csx = 1'b1, exp_oex = 1'b1, exp_wex = 1'b1;
  logic [15:0] exp_dr = 16'h0000;
  bit          exp_writing = 1'b0;

  task automatic model_edge();
    if (rst) begin
      model_valid = 1'b1;
      run1 = 0;
      run0 = 0;
      exp_csx = 1'b1; exp_oex = 1'b1; exp_wex = 1'b1;
      exp_dr = 16'h0000;
      exp_writing = 1'b0;
    end else if (model_valid) begin
      if (!exp_csx && !exp_oex)
        exp_dr = ref_mem[addr];
      if (we) begin
        run1++;
        run0 = 0;
        exp_csx = 1'b0; exp_oex = 1'b1; exp_wex = (run1 >= 2) ? 1'b0 : 1'b1;
        exp_writing = 1'b1;
      end else begin
        run0++;
        run1 = 0;
        exp_csx = 1'b0; exp_oex = (run0 >= 2) ? 1'b0 : 1'b1; exp_wex = 1'b1;
        exp_writing = 1'b0;
      end
    end
  endtask

  // Compare at the falling edge, then commit the write the SRAM should take.
  task automatic probe();
    @(negedge clk);
    if (model_valid) begin
      check("csx", {31'd0, csx}, {31'd0, exp_csx});
      check("oex", {31'd0, oex}, {31'd0, exp_oex});
      check("wex", {31'd0, wex}, {31'd0, exp_wex});
      check("data_read", {16'd0, data_read}, {16'd0, exp_dr});
      if (we && !rst && exp_writing)
        check("bus_drive", {16'd0, data_bus}, {16'd0, dw});
      else if (!exp_csx && !exp_oex)
        check("bus_sram", {16'd0, data_bus}, {16'd0, ref_mem[addr]});
      else
        check_ne("bus_release", {16'd0, data_bus}, {16'd0, dw});
      if (!exp_csx && !exp_wex && we && !rst)
        ref_mem[addr] = dw;
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic tick();
    probe();
    finish_cycle();
  endtask

  function automatic logic [15:0] rand_nz();
    logic [15:0] v;
    do v = 16'($urandom); while (v == 16'h0000);
    return v;
  endfunction

  logic [17:0] addr_tab [0:5];

  function automatic logic [17:0] pick_addr();
    if ($urandom_range(0, 3) == 0)
      return 18'($urandom);
    return addr_tab[$urandom_range(0, 5)];
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    addr_tab[0] = 18'h00000;
    addr_tab[1] = 18'h11111;
    addr_tab[2] = 18'h3FFFF;
    addr_tab[3] = 18'h20001;
    addr_tab[4] = 18'h0ABCD;
    addr_tab[5] = 18'h12345;
    for (int i = 0; i < 262144; i++) begin
      sram_mem[i] = init_word(18'(i));
      ref_mem[i]  = init_word(18'(i));
    end

    rst  = 1'b1;
    we   = 1'b0;
    addr = 18'h00000;
    dw   = 16'hFFFF;
    @(posedge clk);
    #1;

    // Reset held for two edges
    tick();
    tick();
    probe();
    $display("[TB] reset: csx=%b oex=%b wex=%b dr=%h", csx, oex, wex, data_read);
    check("rst_csx", {31'd0, csx}, 32'd1);
    check("rst_oex", {31'd0, oex}, 32'd1);
    check("rst_wex", {31'd0, wex}, 32'd1);
    check("rst_dr", {16'd0, data_read}, 32'h0000);
    check_ne("rst_bus", {16'd0, data_bus}, {16'd0, dw});
    finish_cycle();

    // Release: reading within two edges
    rst = 1'b0;
    tick();
    tick();
    probe();
    $display("[TB] release: csx=%b oex=%b wex=%b", csx, oex, wex);
    check("rel_csx", {31'd0, csx}, 32'd0);
    check("rel_oex", {31'd0, oex}, 32'd0);
    check("rel_wex", {31'd0, wex}, 32'd1);
    finish_cycle();

    // Write 0xAAAA to 0x00000
    addr = 18'h00000; dw = 16'hAAAA; we = 1'b1;
    repeat (4) tick();
    probe();
    $display("[TB] write 00000<=AAAA: csx=%b oex=%b wex=%b bus=%h", csx, oex, wex, data_bus);
    check("wr_csx", {31'd0, csx}, 32'd0);
    check("wr_wex", {31'd0, wex}, 32'd0);
    check("wr_oex", {31'd0, oex}, 32'd1);
    check("wr_bus", {16'd0, data_bus}, 32'hAAAA);
    finish_cycle();

    // Read it back
    we = 1'b0; dw = 16'h0F0F;
    repeat (4) tick();
    probe();
    $display("[TB] read 00000: csx=%b oex=%b wex=%b dr=%h", csx, oex, wex, data_read);
    check("rd_csx", {31'd0, csx}, 32'd0);
    check("rd_oex", {31'd0, oex}, 32'd0);
    check("rd_wex", {31'd0, wex}, 32'd1);
    check("rd_dr_aaaa", {16'd0, data_read}, 32'hAAAA);
    check("sram_mem0", {16'd0, sram_mem[0]}, 32'hAAAA);
    finish_cycle();

    // Write 0x5555 to 0x11111 and read back
    addr = 18'h11111; dw = 16'h5555; we = 1'b1;
    repeat (5) tick();
    we = 1'b0; dw = 16'hF0F0;
    repeat (4) tick();
    probe();
    $display("[TB] read 11111: dr=%h", data_read);
    check("rd_dr_5555", {16'd0, data_read}, 32'h5555);
    finish_cycle();

    // One-cycle WE pulse: no write strobe, memory untouched
    addr = 18'h22222; dw = 16'h1234; we = 1'b1;
    probe();
    finish_cycle();
    we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      probe();
      $display("[TB] pulse cycle %0d: wex=%b", i, wex);
      check("pulse_wex", {31'd0, wex}, 32'd1);
      finish_cycle();
    end
    check("pulse_mem", {16'd0, sram_mem[18'h22222]}, {16'd0, init_word(18'h22222)});

    // Reset during the write pulse
    addr = 18'h33333; dw = 16'hBEEF; we = 1'b1;
    tick();
    tick();
    probe();
    $display("[TB] pulse before reset: wex=%b", wex);
    check("midwr_wex_low", {31'd0, wex}, 32'd0);
    finish_cycle();
    rst = 1'b1;
    probe();
    $display("[TB] reset asserted mid-write: bus=%h", data_bus);
    check_ne("midwr_bus", {16'd0, data_bus}, 32'hBEEF);
    finish_cycle();
    probe();
    $display("[TB] after reset edge: csx=%b wex=%b", csx, wex);
    check("midwr_wex", {31'd0, wex}, 32'd1);
    check("midwr_csx", {31'd0, csx}, 32'd1);
    finish_cycle();
    rst = 1'b0; we = 1'b0;
    tick();

    // Randomized traffic
    for (int burst = 0; burst < 300; burst++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        we  = 1'($urandom);
        dw  = rand_nz();
        repeat ($urandom_range(1, 2)) tick();
        rst = 1'b0;
        we  = 1'b0;
        tick();
      end else begin
        addr = pick_addr();
        dw   = rand_nz();
        we   = 1'b1;
        repeat ($urandom_range(1, 4)) tick();
        we = 1'b0;
        for (int r = 0, n = $urandom_range(1, 6); r < n; r++) begin
          dw = rand_nz();
          if ($urandom_range(0, 1) == 0)
            addr = pick_addr();
          tick();
        end
      end
      if (burst % 50 == 0)
        $display("[TB] random burst %0d: addr=%h dr=%h", burst, addr, data_read);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
